// File: rtl/fetch_queue.sv
// fetch_queue
// Decoupled instruction-fetch unit. Issues reads to a synchronous instruction
// memory (1-cycle latency) and buffers the returned words, tagged with their PC
// and PC+4, in a DEPTH-entry FIFO that the decode stage pops with valid/ready.
// A redirect flushes the FIFO, kills the in-flight read and restarts fetch at
// the target in the same cycle.
//
// Ports
//   w_clk, w_rst     clock, synchronous active-high reset
//   w_imem_en        imem read request this cycle
//   w_imem_addr      imem word address (fetch PC[AW+1:2])
//   w_imem_data      imem read data, valid the cycle after w_imem_en
//   w_redir          taken-branch redirect strobe
//   w_redir_pc       redirect target (bits [1:0] ignored)
//   w_stop           halt new requests; queued words keep draining
//   w_out_valid      FIFO head valid
//   w_out_ready      decode accepts head
//   w_out_ir         head instruction
//   w_out_pc         head PC
//   w_out_pc4        head PC+4
module fetch_queue #(
  parameter int               XLEN     = 32,
  parameter int               AW       = 12,
  parameter int               DEPTH    = 4,
  parameter logic [XLEN-1:0]  RESET_PC = '0
) (
  input  logic            w_clk,
  input  logic            w_rst,
  output logic            w_imem_en,
  output logic [AW-1:0]   w_imem_addr,
  input  logic [XLEN-1:0] w_imem_data,
  input  logic            w_redir,
  input  logic [XLEN-1:0] w_redir_pc,
  input  logic            w_stop,
  output logic            w_out_valid,
  input  logic            w_out_ready,
  output logic [XLEN-1:0] w_out_ir,
  output logic [XLEN-1:0] w_out_pc,
  output logic [XLEN-1:0] w_out_pc4
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [XLEN-1:0] r_pc;
  logic            r_inf;
  logic [XLEN-1:0] r_inf_pc;
  logic [PW-1:0]   r_wr;
  logic [PW-1:0]   r_rd;
  logic [CW-1:0]   r_cnt;
  logic [XLEN-1:0] r_ir   [DEPTH];
  logic [XLEN-1:0] r_pcq  [DEPTH];
  logic [XLEN-1:0] r_pc4q [DEPTH];

  logic [XLEN-1:0] w_target;
  logic [XLEN-1:0] w_issue_pc;
  logic            w_pop;
  logic            w_push;
  logic [CW:0]     w_need;

  assign w_target = {w_redir_pc[XLEN-1:2], 2'b00};

  // The head is hidden during a redirect so the pop in that cycle is ignored.
  assign w_out_valid = !w_rst && !w_redir && (r_cnt != '0);
  assign w_pop       = w_out_valid && w_out_ready;

  // A response landing in a redirect cycle belongs to the wrong path.
  assign w_push = r_inf && !w_redir;

  // Slots committed after this cycle; a pop frees its slot immediately, so a
  // full FIFO being popped can still accept a new request. pop implies r_cnt>=1.
  assign w_need = {1'b0, r_cnt} + (CW+1)'(r_inf) - (CW+1)'(w_pop);

  assign w_imem_en   = !w_rst && !w_stop && (w_redir || (w_need < (CW+1)'(DEPTH)));
  assign w_issue_pc  = w_redir ? w_target : r_pc;
  assign w_imem_addr = w_issue_pc[AW+1:2];

  assign w_out_ir  = r_ir[r_rd];
  assign w_out_pc  = r_pcq[r_rd];
  assign w_out_pc4 = r_pc4q[r_rd];

  always_ff @(posedge w_clk) begin
    if (w_rst) begin
      r_pc     <= RESET_PC;
      r_inf    <= 1'b0;
      r_inf_pc <= '0;
      r_wr     <= '0;
      r_rd     <= '0;
      r_cnt    <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_ir[i]   <= '0;
        r_pcq[i]  <= '0;
        r_pc4q[i] <= '0;
      end
    end else begin
      // The request PC is held for the response cycle to tag the pushed word.
      r_inf <= w_imem_en;
      if (w_imem_en) r_inf_pc <= w_issue_pc;

      if (w_redir) begin
        r_wr  <= '0;
        r_rd  <= '0;
        r_cnt <= '0;
        // Under stop no request goes out, so fetch resumes at the target itself.
        r_pc  <= w_imem_en ? (w_target + XLEN'(4)) : w_target;
      end else begin
        if (w_imem_en) r_pc <= r_pc + XLEN'(4);
        if (w_push) begin
          r_ir[r_wr]   <= w_imem_data;
          r_pcq[r_wr]  <= r_inf_pc;
          r_pc4q[r_wr] <= r_inf_pc + XLEN'(4);
          r_wr         <= r_wr + PW'(1);
        end
        if (w_pop) r_rd <= r_rd + PW'(1);
        r_cnt <= r_cnt + CW'(w_push) - CW'(w_pop);
      end
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue
// Directed bench for fetch_queue. A behavioural imem returns its own word
// address as data, so every output word identifies the request it came from.
module tb_fetch_queue;

  localparam int XLEN  = 32;
  localparam int AW    = 12;
  localparam int DEPTH = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic            imemEn;
  logic [AW-1:0]   imemAddr;
  logic [XLEN-1:0] imemData;
  logic            redir;
  logic [XLEN-1:0] redirPc;
  logic            stop;
  logic            outValid;
  logic            outReady;
  logic [XLEN-1:0] outIr;
  logic [XLEN-1:0] outPc;
  logic [XLEN-1:0] outPc4;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  // Synchronous imem with 1-cycle latency; word i holds value i.
  always @(posedge clk) begin
    if (imemEn) imemData <= {{(XLEN-AW){1'b0}}, imemAddr};
  end

  fetch_queue #(
    .XLEN(XLEN), .AW(AW), .DEPTH(DEPTH), .RESET_PC('0)
  ) dut (
    .w_clk(clk), .w_rst(rst),
    .w_imem_en(imemEn), .w_imem_addr(imemAddr), .w_imem_data(imemData),
    .w_redir(redir), .w_redir_pc(redirPc), .w_stop(stop),
    .w_out_valid(outValid), .w_out_ready(outReady),
    .w_out_ir(outIr), .w_out_pc(outPc), .w_out_pc4(outPc4)
  );

  // Drives one cycle's inputs at the falling edge and lets them settle.
  task automatic drive(input logic r, input logic rd, input logic [XLEN-1:0] rpc,
                       input logic st, input logic rdy);
    @(negedge clk);
    rst = r; redir = rd; redirPc = rpc; stop = st; outReady = rdy;
    #1;
  endtask

  task automatic applyReset;
    drive(1, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0);
  endtask

  task automatic test_reset;
    applyReset();
    vectors++;
    if (imemEn !== 1'b0 || outValid !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL reset_ctl got en=%b valid=%b want en=0 valid=0", imemEn, outValid);
    end
    vectors++;
    if (outIr !== 32'd0 || outPc !== 32'd0 || outPc4 !== 32'd0) begin
      miscompares++;
      $display("[TB] FAIL reset_head got ir=%0h pc=%0h pc4=%0h want 0/0/0", outIr, outPc, outPc4);
    end
  endtask

  task automatic test_stream;
    applyReset();
    for (int c = 0; c < 10; c++) begin
      drive(0, 0, 0, 0, 1);
      vectors++;
      if (imemEn !== 1'b1 || imemAddr !== AW'(c) || outValid !== (c >= 2)) begin
        miscompares++;
        $display("[TB] FAIL stream_ctl c=%0d got en=%b addr=%0h valid=%b want en=1 addr=%0h valid=%0d",
                 c, imemEn, imemAddr, outValid, c, c >= 2);
      end
      if (c >= 2) begin
        vectors++;
        if (outIr !== 32'(c-2) || outPc !== 32'((c-2)*4) || outPc4 !== 32'((c-2)*4+4)) begin
          miscompares++;
          $display("[TB] FAIL stream_head c=%0d got ir=%0h pc=%0h pc4=%0h want %0h/%0h/%0h",
                   c, outIr, outPc, outPc4, c-2, (c-2)*4, (c-2)*4+4);
        end
      end
    end
  endtask

  task automatic test_backpressure;
    applyReset();
    for (int c = 0; c < 8; c++) begin
      drive(0, 0, 0, 0, 0);
      vectors++;
      if (imemEn !== (c < 4) || ((c < 4) && imemAddr !== AW'(c)) || outValid !== (c >= 2)) begin
        miscompares++;
        $display("[TB] FAIL bp_fill c=%0d got en=%b addr=%0h valid=%b want en=%0d addr=%0h valid=%0d",
                 c, imemEn, imemAddr, outValid, c < 4, c, c >= 2);
      end
      if (c >= 2) begin
        vectors++;
        if (outIr !== 32'd0 || outPc !== 32'd0) begin
          miscompares++;
          $display("[TB] FAIL bp_hold c=%0d got ir=%0h pc=%0h want 0/0", c, outIr, outPc);
        end
      end
    end
    for (int c = 8; c < 14; c++) begin
      drive(0, 0, 0, 0, 1);
      vectors++;
      if (imemEn !== 1'b1 || imemAddr !== AW'(c-4) || outValid !== 1'b1 ||
          outIr !== 32'(c-8) || outPc !== 32'((c-8)*4)) begin
        miscompares++;
        $display("[TB] FAIL bp_drain c=%0d got en=%b addr=%0h valid=%b ir=%0h pc=%0h want 1/%0h/1/%0h/%0h",
                 c, imemEn, imemAddr, outValid, outIr, outPc, c-4, c-8, (c-8)*4);
      end
    end
  endtask

  task automatic test_full_single_pop;
    applyReset();
    for (int c = 0; c < 8; c++) drive(0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 1);
    vectors++;
    if (imemEn !== 1'b1 || imemAddr !== AW'(4) || outValid !== 1'b1 || outPc !== 32'd0) begin
      miscompares++;
      $display("[TB] FAIL full_pop got en=%b addr=%0h valid=%b pc=%0h want 1/4/1/0",
               imemEn, imemAddr, outValid, outPc);
    end
    for (int c = 9; c < 11; c++) begin
      drive(0, 0, 0, 0, 0);
      vectors++;
      if (imemEn !== 1'b0 || outValid !== 1'b1 || outIr !== 32'd1 || outPc !== 32'd4) begin
        miscompares++;
        $display("[TB] FAIL full_hold c=%0d got en=%b valid=%b ir=%0h pc=%0h want 0/1/1/4",
                 c, imemEn, outValid, outIr, outPc);
      end
    end
    for (int c = 11; c < 16; c++) begin
      drive(0, 0, 0, 0, 1);
      vectors++;
      if (imemEn !== 1'b1 || imemAddr !== AW'(c-6) || outValid !== 1'b1 ||
          outIr !== 32'(c-10) || outPc !== 32'((c-10)*4)) begin
        miscompares++;
        $display("[TB] FAIL full_drain c=%0d got en=%b addr=%0h valid=%b ir=%0h pc=%0h want 1/%0h/1/%0h/%0h",
                 c, imemEn, imemAddr, outValid, outIr, outPc, c-6, c-10, (c-10)*4);
      end
    end
  endtask

  task automatic test_redirect;
    applyReset();
    for (int c = 0; c < 8; c++) drive(0, 0, 0, 0, 1);
    drive(0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0);
    vectors++;
    if (imemEn !== 1'b1 || imemAddr !== AW'(9) || outValid !== 1'b1 || outPc !== 32'd24) begin
      miscompares++;
      $display("[TB] FAIL redir_pre got en=%b addr=%0h valid=%b pc=%0h want 1/9/1/18",
               imemEn, imemAddr, outValid, outPc);
    end
    drive(0, 1, 32'h103, 0, 1);
    vectors++;
    if (imemEn !== 1'b1 || imemAddr !== AW'('h40) || outValid !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL redir_r got en=%b addr=%0h valid=%b want 1/40/0", imemEn, imemAddr, outValid);
    end
    drive(0, 0, 0, 0, 1);
    vectors++;
    if (imemEn !== 1'b1 || imemAddr !== AW'('h41) || outValid !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL redir_r1 got en=%b addr=%0h valid=%b want 1/41/0", imemEn, imemAddr, outValid);
    end
    for (int k = 0; k < 3; k++) begin
      drive(0, 0, 0, 0, 1);
      vectors++;
      if (outValid !== 1'b1 || outIr !== 32'('h40 + k) || outPc !== 32'('h100 + 4*k) ||
          outPc4 !== 32'('h104 + 4*k)) begin
        miscompares++;
        $display("[TB] FAIL redir_target k=%0d got valid=%b ir=%0h pc=%0h pc4=%0h want 1/%0h/%0h/%0h",
                 k, outValid, outIr, outPc, outPc4, 'h40 + k, 'h100 + 4*k, 'h104 + 4*k);
      end
    end
  endtask

  task automatic test_stop;
    applyReset();
    for (int c = 0; c < 5; c++) drive(0, 0, 0, 0, 1);
    for (int c = 5; c < 9; c++) begin
      drive(0, 0, 0, 1, 1);
      vectors++;
      if (imemEn !== 1'b0 || outValid !== (c < 7) ||
          ((c < 7) && (outIr !== 32'(c-2) || outPc !== 32'((c-2)*4)))) begin
        miscompares++;
        $display("[TB] FAIL stop_drain c=%0d got en=%b valid=%b ir=%0h pc=%0h want 0/%0d/%0h/%0h",
                 c, imemEn, outValid, outIr, outPc, c < 7, c-2, (c-2)*4);
      end
    end
    for (int c = 9; c < 12; c++) begin
      drive(0, 0, 0, 0, 1);
      vectors++;
      if (imemEn !== 1'b1 || imemAddr !== AW'(c-4) || outValid !== (c == 11) ||
          ((c == 11) && (outIr !== 32'd5 || outPc !== 32'd20))) begin
        miscompares++;
        $display("[TB] FAIL stop_resume c=%0d got en=%b addr=%0h valid=%b ir=%0h pc=%0h want 1/%0h/%0d/5/14",
                 c, imemEn, imemAddr, outValid, outIr, outPc, c-4, c == 11);
      end
    end
  endtask

  task automatic test_reset_mid;
    applyReset();
    for (int c = 0; c < 4; c++) drive(0, 0, 0, 0, 0);
    drive(1, 1, 32'h200, 0, 0);
    vectors++;
    if (imemEn !== 1'b0 || outValid !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL rstmid_r got en=%b valid=%b want 0/0", imemEn, outValid);
    end
    for (int c = 5; c < 9; c++) begin
      drive(0, 0, 0, 0, 1);
      vectors++;
      if (imemEn !== 1'b1 || imemAddr !== AW'(c-5) || outValid !== (c >= 7) ||
          ((c >= 7) && (outIr !== 32'(c-7) || outPc !== 32'((c-7)*4)))) begin
        miscompares++;
        $display("[TB] FAIL rstmid_after c=%0d got en=%b addr=%0h valid=%b ir=%0h pc=%0h want 1/%0h/%0d/%0h/%0h",
                 c, imemEn, imemAddr, outValid, outIr, outPc, c-5, c >= 7, c-7, (c-7)*4);
      end
    end
  endtask

  initial begin
    rst = 1'b1; redir = 1'b0; redirPc = '0; stop = 1'b0; outReady = 1'b0;
    test_reset();
    test_stream();
    test_backpressure();
    test_full_single_pop();
    test_redirect();
    test_stop();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
